wm8731_i2s_tx: RTL and testbench



---
 rtl/fm_radio_pkg.sv | 23 ++
 rtl/i2s_clk_gen.sv | 31 +++
 rtl/wm8731_i2s_tx.sv | 110 +++++++++++
 tb/tb_wm8731_i2s_tx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fm_radio_pkg.sv
// Shared types and constants for the radio audio path.
// Edge numbers count BCLK falling edges from the LRCK fall that starts a frame.
package fm_radio_pkg;

    localparam int unsigned WIDTH_AUDIO = 16;
    localparam int unsigned EDGE_W      = 6;

    // Right-channel word select rises with the left LSB (I2S one-bit delay).
    function automatic logic [EDGE_W-1:0] lrck_rise_edge(input int unsigned w);
        return EDGE_W'(w);
    endfunction

    // Trailing edge that drives data low and closes the frame.
    function automatic logic [EDGE_W-1:0] last_edge(input int unsigned w);
        return EDGE_W'(2 * w + 1);
    endfunction

    localparam logic [EDGE_W-1:0] LRCK_RISE_EDGE = lrck_rise_edge(WIDTH_AUDIO);
    localparam logic [EDGE_W-1:0] LAST_EDGE      = last_edge(WIDTH_AUDIO);

    typedef enum logic {IDLE, ACTIVE} state_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S clock generator: MCLK/BCLK from a free-running tick counter in the en48m domain.
// fall_c flags the cycle whose tick update produces the BCLK falling edge.
module i2s_clk_gen #(
    parameter int unsigned bclk_div_log2 = 3,
    parameter int unsigned mclk_div_log2 = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en48m,
    output logic mclk,
    output logic bclk,
    output logic fall_c
);

    localparam int unsigned tick_w = bclk_div_log2 + 1;

    logic [tick_w-1:0] tick;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick <= '0;
        end else if (en48m) begin
            tick <= tick + tick_w'(1);
        end
    end

    assign mclk   = tick[mclk_div_log2];
    assign bclk   = tick[bclk_div_log2];
    assign fall_c = en48m && (tick == '1);

endmodule

// File: rtl/wm8731_i2s_tx.sv
// WM8731 DAC serializer: latches a sample per en32k and sends it as an I2S frame,
// duplicated to left and right, with the FPGA as clock master.
module wm8731_i2s_tx
    import fm_radio_pkg::*;
#(
    parameter int unsigned width_audio   = WIDTH_AUDIO,
    parameter int unsigned bclk_div_log2 = 3,
    parameter int unsigned mclk_div_log2 = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   en48m,
    input  logic                   en32k,
    input  logic [width_audio-1:0] audio_dat,
    input  logic                   mute,
    output logic                   mclk,
    output logic                   bclk,
    output logic                   dac_lr_clk,
    output logic                   dac_dat,
    output logic                   busy,
    output logic                   overrun
);

    localparam int unsigned       frame_w    = 2 * width_audio;
    localparam logic [EDGE_W-1:0] lrck_edge  = lrck_rise_edge(width_audio);
    localparam logic [EDGE_W-1:0] data_edges = EDGE_W'(frame_w);
    localparam logic [EDGE_W-1:0] end_edge   = last_edge(width_audio);

    logic                   fall_c;
    logic                   frame_start_c;
    logic [EDGE_W-1:0]      e_next_c;
    state_t                 state;
    logic [EDGE_W-1:0]      e;
    logic [width_audio-1:0] hold_reg;
    logic [frame_w-1:0]     shreg;
    logic                   pending;

    i2s_clk_gen #(
        .bclk_div_log2(bclk_div_log2),
        .mclk_div_log2(mclk_div_log2)
    ) u_clk_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .en48m  (en48m),
        .mclk   (mclk),
        .bclk   (bclk),
        .fall_c (fall_c)
    );

    assign frame_start_c = fall_c && (state == IDLE) && pending;
    assign e_next_c      = e + EDGE_W'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            e          <= '0;
            hold_reg   <= '0;
            shreg      <= '0;
            pending    <= 1'b0;
            dac_lr_clk <= 1'b1;
            dac_dat    <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // A start in the same cycle as a strobe consumes the old sample, so no overrun.
            if (en32k) begin
                hold_reg <= mute ? '0 : audio_dat;
                pending  <= 1'b1;
                if (pending && !frame_start_c) begin
                    overrun <= 1'b1;
                end
            end else if (frame_start_c) begin
                pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    dac_lr_clk <= 1'b1;
                    dac_dat    <= 1'b0;
                    if (frame_start_c) begin
                        shreg      <= {hold_reg, hold_reg};
                        dac_lr_clk <= 1'b0;
                        e          <= '0;
                        busy       <= 1'b1;
                        state      <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (fall_c) begin
                        e <= e_next_c;
                        if (e_next_c <= data_edges) begin
                            dac_dat <= shreg[frame_w-1];
                            shreg   <= {shreg[frame_w-2:0], 1'b0};
                        end
                        if (e_next_c == lrck_edge) begin
                            dac_lr_clk <= 1'b1;
                        end
                        if (e_next_c == end_edge) begin
                            dac_dat <= 1'b0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wm8731_i2s_tx.sv
// Self-checking bench for wm8731_i2s_tx: decodes the I2S pins on BCLK rises and
// compares each frame with the sample that was strobed in.
module tb_wm8731_i2s_tx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en48m;
    logic        en32k;
    logic [15:0] audio_dat;
    logic        mute;
    logic        mclk, bclk, dac_lr_clk, dac_dat, busy, overrun;

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    int model_tick = 0;

    wm8731_i2s_tx dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en48m     (en48m),
        .en32k     (en32k),
        .audio_dat (audio_dat),
        .mute      (mute),
        .mclk      (mclk),
        .bclk      (bclk),
        .dac_lr_clk(dac_lr_clk),
        .dac_dat   (dac_dat),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #2 clk = ~clk;

    // en48m: one clk in five, changed just after the rising edge
    initial begin
        int c;
        c = 0;
        en48m = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            c = (c + 1) % 5;
            en48m = (c == 0);
        end
    end

    // Reference tick count: en48m ticks since reset, modulo one BCLK period
    always @(posedge clk) begin
        if (!reset_n) model_tick <= 0;
        else if (en48m) model_tick <= (model_tick + 1) % 16;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] v, input logic m);
        @(negedge clk);
        en32k = 1'b1;
        audio_dat = v;
        mute = m;
        @(negedge clk);
        en32k = 1'b0;
        mute = 1'b0;
    endtask

    // Waits for LRCK fall, then records data/LRCK on BCLK rises 1..32 (rise 0 precedes data)
    task automatic capture(input bit edge_chk, output logic [31:0] bits,
                           output logic [31:0] lrs, output int lat);
        logic pb;
        int   k;
        bits = '0;
        lrs  = '0;
        lat  = -1;
        pb   = bclk;
        for (int n = 1; n <= 120; n++) begin
            @(negedge clk);
            if (dac_lr_clk == 1'b0) begin
                lat = n;
                break;
            end
            pb = bclk;
        end
        check("lrck_fall", 32'(dac_lr_clk), 32'h0);
        if (lat < 0) return;
        if (edge_chk) check("lrck_on_bclk_fall", 32'({pb, bclk}), 32'h2);
        k  = 0;
        pb = bclk;
        for (int n = 0; n < 34 * 80 && k < 33; n++) begin
            @(negedge clk);
            if (bclk && !pb) begin
                if (k >= 1) begin
                    bits[32-k] = dac_dat;
                    lrs[32-k]  = dac_lr_clk;
                end
                k++;
            end
            pb = bclk;
        end
        check("rise_count", 32'(k), 32'd33);
        for (int n = 0; n < 100 && busy; n++) @(negedge clk);
        check("frame_end", 32'({busy, dac_dat, dac_lr_clk}), 32'h1);
    endtask

    task automatic run_frame(input string tag, input logic [15:0] v, input logic m);
        logic [31:0] bits, lrs;
        logic [15:0] s;
        int          lat;
        s = m ? 16'h0 : v;
        send(v, m);
        capture(1'b1, bits, lrs, lat);
        check({tag, "_data"}, bits, {s, s});
        check({tag, "_lrck"}, lrs, 32'h0001_FFFF);
        check({tag, "_latency"}, 32'(lat >= 1 && lat <= 80), 32'h1);
    endtask

    initial begin
        logic [31:0] bits, lrs;
        logic [15:0] v1, v2;
        int          lat, hi, bad, edges;
        int          mr[$], br[$], bf[$];
        logic        pm, pb;

        reset_n = 1'b0;
        en32k = 1'b0;
        audio_dat = '0;
        mute = 1'b0;

        // reset values
        repeat (20) @(negedge clk);
        check("reset_outputs", 32'({mclk, bclk, dac_lr_clk, dac_dat, busy, overrun}), 32'h08);
        reset_n = 1'b1;

        // clock periods and duty
        pm = mclk;
        pb = bclk;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (mclk && !pm) mr.push_back(i);
            if (bclk && !pb) br.push_back(i);
            if (!bclk && pb) bf.push_back(i);
            pm = mclk;
            pb = bclk;
        end
        check("clk_edges_seen", 32'(mr.size() >= 3 && br.size() >= 2 && bf.size() >= 2), 32'h1);
        if (mr.size() >= 3 && br.size() >= 2 && bf.size() >= 2) begin
            check("mclk_period", 32'(mr[2] - mr[1]), 32'd20);
            check("bclk_period", 32'(br[1] - br[0]), 32'd80);
            hi = -1;
            foreach (bf[j]) if (hi < 0 && bf[j] > br[0]) hi = bf[j] - br[0];
            check("bclk_high", 32'(hi), 32'd40);
        end

        // directed frames
        run_frame("a5c3", 16'hA5C3, 1'b0);
        run_frame("negfs", 16'h8000, 1'b0);
        run_frame("mute", 16'h8000, 1'b1);

        // random samples, occasionally muted
        for (int i = 0; i < 4; i++) begin
            run_frame("rand", 16'($urandom), ($urandom % 4) == 0);
        end
        check("no_overrun_nominal", 32'(overrun), 32'h0);

        // strobe coincident with the frame-start fall strobe
        v2 = 16'($urandom);
        send(16'h1234, 1'b0);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (en48m && model_tick == 15) break;
        end
        en32k = 1'b1;
        audio_dat = v2;
        @(negedge clk);
        en32k = 1'b0;
        capture(1'b0, bits, lrs, lat);
        check("coinc_first", bits, 32'h1234_1234);
        capture(1'b1, bits, lrs, lat);
        check("coinc_second", bits, {v2, v2});
        check("coinc_no_overrun", 32'(overrun), 32'h0);

        // two strobes 10 clk apart before any fall strobe
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (model_tick == 1) break;
        end
        v1 = 16'($urandom);
        v2 = 16'($urandom);
        send(v1, 1'b0);
        repeat (8) @(negedge clk);
        send(v2, 1'b0);
        capture(1'b1, bits, lrs, lat);
        check("overrun_data", bits, {v2, v2});
        check("overrun_set", 32'(overrun), 32'h1);
        run_frame("after_ovr", 16'h0F0F, 1'b0);
        check("overrun_sticky", 32'(overrun), 32'h1);

        // reset asserted at edge 10 of a frame
        send(16'hFFFF, 1'b0);
        edges = -1;
        pb = bclk;
        for (int n = 0; n < 2000 && edges < 10; n++) begin
            @(negedge clk);
            if (edges < 0 && dac_lr_clk == 1'b0) edges = 0;
            else if (edges >= 0 && pb && !bclk) edges++;
            pb = bclk;
        end
        check("midreset_reached_edge10", 32'(edges), 32'd10);
        check("midreset_busy_before", 32'(busy), 32'h1);
        reset_n = 1'b0;
        @(negedge clk);
        check("midreset_outputs", 32'({mclk, bclk, dac_lr_clk, dac_dat, busy, overrun}), 32'h08);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (!dac_lr_clk || busy || dac_dat) bad++;
        end
        check("no_residual_frame", 32'(bad), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
